// File: rtl/alu_sequencer.sv
// alu_sequencer: register file feeding a 16-bit ALU through READ_A, READ_B, EXEC and WRITE states.
// Holds its own copy of the 16-bit ALU execute unit so the design stays in one file.
module alu (
    input  logic [15:0] Ain,
    input  logic [15:0] Bin,
    input  logic [1:0]  ALUop,
    output logic [15:0] out,
    output logic        Z
);
    always_comb begin
        out = ALUop == 2'b00 ? Ain + Bin :
              ALUop == 2'b01 ? Ain - Bin :
              ALUop == 2'b10 ? Ain & Bin : ~Bin;
        Z = out == 16'h0000;
    end
endmodule

module alu_sequencer #(
    parameter int NREG = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [2:0]  rn,
    input  logic [2:0]  rm,
    input  logic [2:0]  rd,
    input  logic [1:0]  shift,
    input  logic        ld,
    input  logic [2:0]  ld_idx,
    input  logic [15:0] ld_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        z
);
    typedef enum logic [2:0] {IDLE, READ_A, READ_B, EXEC, WRITE} state_t;
    state_t      state;
    logic [15:0] regs [NREG];
    logic [15:0] a, b, rm_val, b_shifted, alu_out;
    logic [1:0]  op_q, shift_q;
    logic [2:0]  rn_q, rm_q, rd_q;
    logic        alu_z;
    always_comb begin
        rm_val = regs[rm_q];
        b_shifted = shift_q == 2'b01 ? {rm_val[14:0], 1'b0} :
                    shift_q == 2'b10 ? {1'b0, rm_val[15:1]} :
                    shift_q == 2'b11 ? {rm_val[15], rm_val[15:1]} : rm_val;
    end
    alu u_alu (.Ain(a), .Bin(b), .ALUop(op_q), .out(alu_out), .Z(alu_z));
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            a       <= '0;
            b       <= '0;
            result  <= '0;
            z       <= 1'b0;
            op_q    <= '0;
            shift_q <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            rd_q    <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // start takes priority; a load only lands when no operation begins
                    if (start) begin
                        op_q    <= op;
                        rn_q    <= rn;
                        rm_q    <= rm;
                        rd_q    <= rd;
                        shift_q <= shift;
                        busy    <= 1'b1;
                        state   <= READ_A;
                    end else if (ld) begin
                        regs[ld_idx] <= ld_data;
                    end
                end
                READ_A: begin
                    a     <= regs[rn_q];
                    state <= READ_B;
                end
                READ_B: begin
                    b     <= b_shifted;
                    state <= EXEC;
                end
                EXEC: begin
                    result <= alu_out;
                    z      <= alu_z;
                    done   <= 1'b1;
                    state  <= WRITE;
                end
                WRITE: begin
                    regs[rd_q] <= result;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed tests of the alu_sequencer with hand-computed expectations.
module tb_alu_sequencer;
    logic        clk = 0, reset = 1, start = 0, ld = 0;
    logic [1:0]  op = 0, shift = 0;
    logic [2:0]  rn = 0, rm = 0, rd = 0, ld_idx = 0;
    logic [15:0] ld_data = 0;
    logic        busy, done, z;
    logic [15:0] result;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rn(rn), .rm(rm), .rd(rd),
        .shift(shift), .ld(ld), .ld_idx(ld_idx), .ld_data(ld_data),
        .busy(busy), .done(done), .result(result), .z(z)
    );

    task automatic do_ld(input logic [2:0] idx, input logic [15:0] data);
        @(negedge clk); ld = 1; ld_idx = idx; ld_data = data;
        @(negedge clk); ld = 0;
    endtask

    // returns at the negedge after the start edge; inputs are scrambled to prove they were latched
    task automatic start_op(input logic [1:0] o, input logic [2:0] a, input logic [2:0] bb,
                            input logic [2:0] d, input logic [1:0] s);
        @(negedge clk); start = 1; op = o; rn = a; rm = bb; rd = d; shift = s;
        @(negedge clk); start = 0; op = ~o; rn = ~a; rm = ~bb; rd = ~d; shift = ~s;
    endtask

    task automatic test_reset;
        reset = 1; ld = 1; ld_idx = 3; ld_data = 16'h0099; start = 1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (result !== 16'h0000) begin errors++; $display("FAIL reset_result: got %h want 0000", result); end
        checks++; if (z !== 1'b0) begin errors++; $display("FAIL reset_z: got %b want 0", z); end
        checks++; if (dut.regs[3] !== 16'h0000) begin errors++; $display("FAIL reset_ld_override: got %h want 0000", dut.regs[3]); end
        reset = 0; ld = 0; start = 0;
    endtask

    task automatic test_add;
        do_ld(0, 16'h0002); do_ld(1, 16'h0004);
        start_op(2'b00, 0, 1, 2, 2'b00);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL add_busy: got %b want 1", busy); end
        repeat (2) @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL add_early_done: got %b want 0", done); end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL add_done: got %b want 1", done); end
        checks++; if (result !== 16'h0006) begin errors++; $display("FAIL add_result: got %h want 0006", result); end
        checks++; if (z !== 1'b0) begin errors++; $display("FAIL add_z: got %b want 0", z); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL add_end: got done=%b busy=%b want 0 0", done, busy); end
        checks++; if (dut.regs[2] !== 16'h0006) begin errors++; $display("FAIL add_wb: got %h want 0006", dut.regs[2]); end
    endtask

    task automatic test_sub;
        do_ld(1, 16'h0002); do_ld(3, 16'hFFFF);
        start_op(2'b01, 0, 1, 3, 2'b00);
        repeat (2) @(negedge clk);
        checks++; if (result !== 16'h0006) begin errors++; $display("FAIL sub_hold: got %h want 0006", result); end
        @(negedge clk);
        checks++; if (result !== 16'h0000 || z !== 1'b1) begin errors++; $display("FAIL sub_result: got %h z=%b want 0000 z=1", result, z); end
        @(negedge clk);
        checks++; if (dut.regs[3] !== 16'h0000) begin errors++; $display("FAIL sub_wb: got %h want 0000", dut.regs[3]); end
    endtask

    task automatic test_not_asr;
        do_ld(1, 16'h8004);
        start_op(2'b11, 0, 1, 4, 2'b11);
        repeat (2) @(negedge clk);
        checks++; if (dut.b !== 16'hC002) begin errors++; $display("FAIL asr_b: got %h want c002", dut.b); end
        @(negedge clk);
        checks++; if (result !== 16'h3FFD || z !== 1'b0) begin errors++; $display("FAIL not_result: got %h z=%b want 3ffd z=0", result, z); end
        @(negedge clk);
        checks++; if (dut.regs[4] !== 16'h3FFD) begin errors++; $display("FAIL not_wb: got %h want 3ffd", dut.regs[4]); end
    endtask

    task automatic test_shifts;
        logic [1:0]  t_op [5] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01};
        logic [2:0]  t_rn [5] = '{3'd6, 3'd6, 3'd6, 3'd5, 3'd6};
        logic [1:0]  t_sh [5] = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b00};
        logic [15:0] t_ex [5] = '{16'h0002, 16'h4000, 16'hC000, 16'h0000, 16'h7FFF};
        do_ld(5, 16'h8001);
        for (int i = 0; i < 5; i++) begin
            start_op(t_op[i], t_rn[i], 5, 2, t_sh[i]);
            repeat (3) @(negedge clk);
            checks++; if (result !== t_ex[i] || z !== (t_ex[i] == 16'h0)) begin errors++; $display("FAIL shift_%0d: got %h z=%b want %h", i, result, z, t_ex[i]); end
            @(negedge clk);
            checks++; if (dut.regs[2] !== t_ex[i]) begin errors++; $display("FAIL shift_wb_%0d: got %h want %h", i, dut.regs[2], t_ex[i]); end
        end
    endtask

    task automatic test_alias;
        do_ld(0, 16'h0007);
        start_op(2'b00, 0, 0, 0, 2'b00);
        repeat (3) @(negedge clk);
        checks++; if (dut.regs[0] !== 16'h0007) begin errors++; $display("FAIL alias_pre: got %h want 0007", dut.regs[0]); end
        @(negedge clk);
        checks++; if (dut.regs[0] !== 16'h000E) begin errors++; $display("FAIL alias_wb: got %h want 000e", dut.regs[0]); end
    endtask

    task automatic test_back_to_back;
        do_ld(0, 16'h0003); do_ld(1, 16'h0005);
        @(negedge clk); start = 1; op = 0; rn = 0; rm = 1; rd = 2; shift = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) rn = 1;
            checks++; if (busy !== !(i == 4 || i == 9)) begin errors++; $display("FAIL b2b_busy_%0d: got %b want %b", i, busy, !(i == 4 || i == 9)); end
            checks++; if (done !== (i == 3 || i == 8)) begin errors++; $display("FAIL b2b_done_%0d: got %b want %b", i, done, (i == 3 || i == 8)); end
            if (i == 3) begin checks++; if (result !== 16'h0008) begin errors++; $display("FAIL b2b_first: got %h want 0008", result); end end
            if (i == 8) begin checks++; if (result !== 16'h000A) begin errors++; $display("FAIL b2b_second: got %h want 000a", result); end end
            if (i == 9) start = 0;
        end
        checks++; if (dut.regs[2] !== 16'h000A) begin errors++; $display("FAIL b2b_wb: got %h want 000a", dut.regs[2]); end
    endtask

    task automatic test_ld_start;
        do_ld(7, 16'h1234);
        @(negedge clk); start = 1; op = 0; rn = 0; rm = 1; rd = 6; shift = 0; ld = 1; ld_idx = 7; ld_data = 16'hBEEF;
        @(negedge clk); start = 0; ld_data = 16'hAAAA;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        @(negedge clk);
        checks++; if (done !== 1'b1 || result !== 16'h0008) begin errors++; $display("FAIL ldst_result: got done=%b %h want 1 0008", done, result); end
        @(negedge clk); ld = 0;
        checks++; if (dut.regs[7] !== 16'h1234) begin errors++; $display("FAIL ldst_ignored: got %h want 1234", dut.regs[7]); end
        checks++; if (dut.regs[6] !== 16'h0008) begin errors++; $display("FAIL ldst_wb: got %h want 0008", dut.regs[6]); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_queued: got %b want 0", busy); end
        do_ld(6, 16'h0000);
        checks++; if (result !== 16'h0008 || z !== 1'b0) begin errors++; $display("FAIL result_hold: got %h z=%b want 0008 z=0", result, z); end
    endtask

    task automatic test_reset_mid;
        start_op(2'b00, 0, 1, 5, 2'b00);
        @(negedge clk);
        @(negedge clk); reset = 1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rmid_ctrl: got busy=%b done=%b want 0 0", busy, done); end
        checks++; if (result !== 16'h0000 || dut.a !== 16'h0000 || dut.b !== 16'h0000) begin errors++; $display("FAIL rmid_data: got %h %h %h want 0", result, dut.a, dut.b); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (dut.regs[i] !== 16'h0000) begin errors++; $display("FAIL rmid_reg%0d: got %h want 0000", i, dut.regs[i]); end
        end
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_after_%0d: got done=%b busy=%b want 0 0", i, done, busy); end
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub;
        test_not_asr;
        test_shifts;
        test_alias;
        test_back_to_back;
        test_ld_start;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
